// File: rtl/cpu_fetch_unit_if.sv
// Fetch-stage bus: program ROM port, instruction hand-off to the ALU datapath,
// and the redirect/stall controls coming back from the execute side.
interface cpu_fetch_unit_if #(
  parameter int PC_WIDTH = 9
);
  logic [PC_WIDTH-1:0] prog_addr;
  logic [11:0]         prog_data;
  logic [11:0]         instruction_out;
  logic                instr_valid;
  logic                stall;
  logic                skip_req;
  logic                pcl_write;
  logic [7:0]          pcl_data;
  logic [PC_WIDTH-1:0] pc_out;

  // Core side drives ROM stimulus and controls, observes fetch outputs.
  modport master (
    input  prog_addr, instruction_out, instr_valid, pc_out,
    output prog_data, stall, skip_req, pcl_write, pcl_data
  );

  // Fetch unit side.
  modport slave (
    output prog_addr, instruction_out, instr_valid, pc_out,
    input  prog_data, stall, skip_req, pcl_write, pcl_data
  );
endinterface

// File: rtl/cpu_fetch_unit.sv
// PIC10-style instruction fetch: program counter, 2-entry return stack and
// instruction register. GOTO/CALL/RETLW/PCL writes/skips redirect locally and
// leave a one-cycle bubble behind them.
module cpu_fetch_unit #(
  parameter int                  PC_WIDTH     = 9,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '1
) (
  input logic           clk,
  input logic           rst,
  cpu_fetch_unit_if.slave bus
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [11:0]         ir_q, ir_d;
  logic                ir_valid_q, ir_valid_d;
  logic [PC_WIDTH-1:0] stack1_q, stack1_d;
  logic [PC_WIDTH-1:0] stack2_q, stack2_d;

  logic [PC_WIDTH-1:0] pc_inc;
  logic                is_goto, is_call, is_retlw;

  assign pc_inc   = pc_q + 1'b1;
  assign is_goto  = (ir_q[11:9] == 3'b101);
  assign is_call  = (ir_q[11:8] == 4'b1001);
  assign is_retlw = (ir_q[11:8] == 4'b1000);

  // Next fetch state: sequential advance unless a valid instruction redirects.
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    stack1_d   = stack1_q;
    stack2_d   = stack2_q;
    if (!bus.stall) begin
      ir_d       = bus.prog_data;
      ir_valid_d = 1'b1;
      pc_d       = pc_inc;
      // A bubble never redirects, so two redirects cannot follow each other.
      if (ir_valid_q) begin
        if (is_goto) begin
          pc_d       = PC_WIDTH'(ir_q[8:0]);
          ir_valid_d = 1'b0;
        end else if (is_call) begin
          stack2_d   = stack1_q;
          stack1_d   = pc_q;
          pc_d       = PC_WIDTH'({1'b0, ir_q[7:0]});
          ir_valid_d = 1'b0;
        end else if (is_retlw) begin
          pc_d       = stack1_q;
          stack1_d   = stack2_q;
          ir_valid_d = 1'b0;
        end else if (bus.pcl_write) begin
          pc_d       = PC_WIDTH'(bus.pcl_data);
          ir_valid_d = 1'b0;
        end else if (bus.skip_req) begin
          ir_valid_d = 1'b0;
        end
      end
    end
  end

  // Fetch state registers; reset abandons any pending redirect or stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_VECTOR;
      ir_q       <= 12'h000;
      ir_valid_q <= 1'b0;
      stack1_q   <= '0;
      stack2_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      stack1_q   <= stack1_d;
      stack2_q   <= stack2_d;
    end
  end

  assign bus.prog_addr       = pc_q;
  assign bus.pc_out          = pc_q;
  assign bus.instr_valid     = ir_valid_q;
  assign bus.instruction_out = ir_valid_q ? ir_q : 12'h000;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Directed bench for cpu_fetch_unit with an instruction-level reference model
// checked every cycle, plus literal expectations at the interesting points.
module tb_cpu_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_fetch_unit_if #(.PC_WIDTH(9)) bus ();

  cpu_fetch_unit #(.PC_WIDTH(9), .RESET_VECTOR(9'h1FF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [11:0] mem [512];
  assign bus.prog_data = mem[bus.prog_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (architectural view) ----------------
  // m_pc: address being fetched; m_ir/m_valid: what the execute stage sees;
  // ret[0] is the most recent return address, ret[1] the older one.
  logic [8:0]  m_pc;
  logic [11:0] m_ir;
  logic        m_valid;
  logic [8:0]  ret [2];

  always @(posedge clk or negedge rst) begin : model
    logic [8:0] target;
    logic       redirect;
    if (!rst) begin
      m_pc    <= 9'h1FF;
      m_ir    <= 12'h000;
      m_valid <= 1'b0;
      ret[0]  <= 9'h000;
      ret[1]  <= 9'h000;
    end else if (!bus.stall) begin
      target   = m_pc + 9'd1;
      redirect = 1'b0;
      if (m_valid) begin
        casez (m_ir)
          12'b101?_????_????: begin target = m_ir[8:0]; redirect = 1'b1; end
          12'b1001_????_????: begin
            target = {1'b0, m_ir[7:0]};
            redirect = 1'b1;
            ret[0] <= m_pc;
            ret[1] <= ret[0];
          end
          12'b1000_????_????: begin
            target = ret[0];
            redirect = 1'b1;
            ret[0] <= ret[1];
          end
          default: begin
            if (bus.pcl_write) begin
              target = {1'b0, bus.pcl_data};
              redirect = 1'b1;
            end else if (bus.skip_req) begin
              redirect = 1'b1;
            end
          end
        endcase
      end
      m_ir    <= mem[m_pc];
      m_valid <= !redirect;
      m_pc    <= target;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_pc_out", {23'd0, bus.pc_out}, {23'd0, m_pc});
    check("model_prog_addr", {23'd0, bus.prog_addr}, {23'd0, m_pc});
    check("model_valid", {31'd0, bus.instr_valid}, {31'd0, m_valid});
    check("model_instr", {20'd0, bus.instruction_out}, {20'd0, m_valid ? m_ir : 12'h000});
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic hold_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    bus.stall = 1'b0; bus.skip_req = 1'b0; bus.pcl_write = 1'b0; bus.pcl_data = 8'h00;
    for (int i = 0; i < 512; i++) mem[i] = 12'h600 | 12'(i);
  endtask

  task automatic release_reset();
    step();
    check("rst_prog_addr", {23'd0, bus.prog_addr}, 32'h1FF);
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_instr", {20'd0, bus.instruction_out}, 32'h000);
    #1 rst = 1'b1;
  endtask

  // Advance until the instruction at addr is the one executing.
  task automatic wait_exec(input logic [8:0] addr);
    bit found = 0;
    for (int c = 0; c < 700 && !found; c++) begin
      step();
      if (bus.instr_valid && bus.pc_out == addr + 9'd1) found = 1;
    end
    if (!found) check("wait_exec_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_bubble(input string name, input logic [8:0] pc);
    check({name, "_bubble_valid"}, {31'd0, bus.instr_valid}, 32'd0);
    check({name, "_bubble_instr"}, {20'd0, bus.instruction_out}, 32'h000);
    check({name, "_bubble_pc"}, {23'd0, bus.pc_out}, {23'd0, pc});
  endtask

  task automatic expect_instr(input string name, input logic [11:0] ins, input logic [8:0] pc);
    check({name, "_valid"}, {31'd0, bus.instr_valid}, 32'd1);
    check({name, "_instr"}, {20'd0, bus.instruction_out}, {20'd0, ins});
    check({name, "_pc"}, {23'd0, bus.pc_out}, {23'd0, pc});
  endtask

  initial begin
    bus.stall = 1'b0; bus.skip_req = 1'b0; bus.pcl_write = 1'b0; bus.pcl_data = 8'h00;

    // Reset and wrap from the reset vector to 0.
    hold_reset();
    mem[9'h1FF] = 12'hC05;
    release_reset();
    step(); expect_instr("rst_first", 12'hC05, 9'h000);
    step(); expect_instr("rst_mem0", 12'h600, 9'h001);
    step(); expect_instr("rst_mem1", 12'h601, 9'h002);

    // GOTO 0x040 at 0x010.
    hold_reset();
    mem[9'h010] = 12'hA40;
    release_reset();
    wait_exec(9'h010);
    step(); expect_bubble("goto", 9'h040);
    step(); expect_instr("goto_tgt", 12'h640, 9'h041);

    // Three nested CALLs, then three RETLWs; oldest return address is lost.
    hold_reset();
    mem[9'h005] = 12'h920;
    mem[9'h021] = 12'h930;
    mem[9'h031] = 12'h940;
    mem[9'h040] = 12'h8AA;
    mem[9'h032] = 12'h811;
    mem[9'h022] = 12'h822;
    release_reset();
    wait_exec(9'h005);
    step(); expect_bubble("call1", 9'h020);
    step(); expect_instr("call1_tgt", 12'h620, 9'h021);
    wait_exec(9'h040);
    step(); expect_bubble("ret1", 9'h032);
    step(); expect_instr("ret1_tgt", 12'h811, 9'h033);
    step(); expect_bubble("ret2", 9'h022);
    step(); expect_instr("ret2_tgt", 12'h822, 9'h023);
    step(); expect_bubble("ret3", 9'h022);
    step(); expect_instr("ret3_tgt", 12'h822, 9'h023);

    // Taken skip at 0x008 discards 0x009.
    hold_reset();
    release_reset();
    wait_exec(9'h008);
    bus.skip_req = 1'b1;
    step(); expect_bubble("skip", 9'h00A);
    bus.skip_req = 1'b0;
    step(); expect_instr("skip_next", 12'h60A, 9'h00B);

    // PCL write while pc_out = 0x1A0.
    hold_reset();
    mem[9'h000] = 12'hB9F;
    release_reset();
    wait_exec(9'h19F);
    check("pcl_pc_before", {23'd0, bus.pc_out}, 32'h1A0);
    bus.pcl_write = 1'b1; bus.pcl_data = 8'h80;
    step(); expect_bubble("pcl", 9'h080);
    bus.pcl_write = 1'b0;
    step(); expect_instr("pcl_tgt", 12'h680, 9'h081);

    // Stall with GOTO in ir and skip_req asserted; GOTO wins on release.
    hold_reset();
    mem[9'h003] = 12'hA50;
    release_reset();
    wait_exec(9'h003);
    bus.stall = 1'b1; bus.skip_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); expect_instr("stall_hold", 12'hA50, 9'h004);
    end
    bus.stall = 1'b0;
    step(); expect_bubble("stall_goto", 9'h050);
    bus.skip_req = 1'b0;
    step(); expect_instr("stall_goto_tgt", 12'h650, 9'h051);

    // Reset in the middle of a stall drops everything immediately.
    bus.stall = 1'b1;
    step();
    #1 rst = 1'b0;
    #1 check("midstall_rst_pc", {23'd0, bus.pc_out}, 32'h1FF);
    check("midstall_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    bus.stall = 1'b0;
    step();
    #1 rst = 1'b1;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
